nes_clk_seq: RTL and testbench



---
 rtl/nes_clk_pkg.sv | 9 +
 rtl/nes_clk_seq_sync_2ff.sv | 17 +
 rtl/nes_clk_seq.sv | 76 +++++++
 tb/tb_nes_clk_seq.sv | 130 +++++++++++++
 4 files changed

// File: rtl/nes_clk_pkg.sv
// nes_clk_pkg: shared types and defaults for the NES clock/reset sequencer.
package nes_clk_pkg;
   typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} seq_state_t;
   localparam int LOCK_STABLE_DEF = 1024;
   localparam int RST_HOLD_DEF    = 16;
   localparam int CPU_DIV_DEF     = 12;
   localparam int PPU_DIV_DEF     = 4;
   localparam int DROP_W          = 8;
endpackage

// File: rtl/nes_clk_seq_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous level flag.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_meta <= 1'b0;
         o_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         o_q    <= r_meta;
      end
endmodule

// File: rtl/nes_clk_seq.sv
// nes_clk_seq: lock-qualified core reset and CPU/PPU clock-enable generator.
module nes_clk_seq
   import nes_clk_pkg::*;
#(
   parameter int LOCK_STABLE = LOCK_STABLE_DEF,
   parameter int RST_HOLD    = RST_HOLD_DEF,
   parameter int CPU_DIV     = CPU_DIV_DEF,
   parameter int PPU_DIV     = PPU_DIV_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lock,
   output logic              sys_reset,
   output logic              ready,
   output logic              ce_cpu,
   output logic              ce_ppu,
   output logic [DROP_W-1:0] lock_drop_cnt
);
   localparam int CMAX = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
   localparam int CW   = $clog2(CMAX);
   localparam int DCW  = $clog2(CPU_DIV);
   localparam int DPW  = (PPU_DIV > 1) ? $clog2(PPU_DIV) : 1;

   logic           w_lock_s;
   seq_state_t     r_state, w_state_n;
   logic [CW-1:0]  r_cnt, w_cnt_n;
   logic [DCW-1:0] r_dc, w_dc_n;
   logic [DPW-1:0] r_dp, w_dp_n;
   logic           w_run_n, w_drop;

   sync_2ff u_sync (
      .i_clk (clk),
      .i_rst (reset),
      .i_d   (lock),
      .o_q   (w_lock_s)
   );

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         WAIT_LOCK: if (w_lock_s) w_state_n = STABLE;
         STABLE:    w_state_n = !w_lock_s ? WAIT_LOCK : (r_cnt == CW'(LOCK_STABLE - 1)) ? HOLD : STABLE;
         HOLD:      w_state_n = !w_lock_s ? WAIT_LOCK : (r_cnt == CW'(RST_HOLD - 1)) ? RUN : HOLD;
         RUN:       if (!w_lock_s) w_state_n = WAIT_LOCK;
      endcase
      w_cnt_n = (w_state_n != r_state || r_state == WAIT_LOCK || r_state == RUN) ? '0 : r_cnt + 1'b1;
      w_run_n = (w_state_n == RUN);
      // dividers start from 0 on the first RUN cycle and wrap at their period
      w_dc_n  = (!w_run_n || r_state != RUN || r_dc == DCW'(CPU_DIV - 1)) ? '0 : r_dc + 1'b1;
      w_dp_n  = (!w_run_n || r_state != RUN || r_dp == DPW'(PPU_DIV - 1)) ? '0 : r_dp + 1'b1;
      w_drop  = (r_state == RUN) && !w_run_n && (lock_drop_cnt != '1);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state       <= WAIT_LOCK;
         r_cnt         <= '0;
         r_dc          <= '0;
         r_dp          <= '0;
         sys_reset     <= 1'b1;
         ready         <= 1'b0;
         ce_cpu        <= 1'b0;
         ce_ppu        <= 1'b0;
         lock_drop_cnt <= '0;
      end else begin
         r_state       <= w_state_n;
         r_cnt         <= w_cnt_n;
         r_dc          <= w_dc_n;
         r_dp          <= w_dp_n;
         sys_reset     <= !w_run_n;
         ready         <= w_run_n;
         ce_cpu        <= w_run_n && (w_dc_n == DCW'(CPU_DIV - 1));
         ce_ppu        <= w_run_n && (w_dp_n == DPW'(PPU_DIV - 1));
         lock_drop_cnt <= w_drop ? lock_drop_cnt + 1'b1 : lock_drop_cnt;
      end
endmodule

// File: tb/tb_nes_clk_seq.sv
// tb_nes_clk_seq: directed lock/reset scenarios checked against a lock-history model.
module tb_nes_clk_seq;
   import nes_clk_pkg::*;
   localparam int LS = 8, RH = 4, CD = 12, PD = 4;
   localparam int N  = LS + RH + 1;

   logic       clk = 0, reset = 1, lock = 0;
   logic       sys_reset, ready, ce_cpu, ce_ppu;
   logic [7:0] lock_drop_cnt;
   int         total = 0, bad = 0;
   bit         chk_on = 0;

   always #5 clk = ~clk;

   nes_clk_seq #(.LOCK_STABLE(LS), .RST_HOLD(RH), .CPU_DIV(CD), .PPU_DIV(PD)) dut (
      .clk           (clk),
      .reset         (reset),
      .lock          (lock),
      .sys_reset     (sys_reset),
      .ready         (ready),
      .ce_cpu        (ce_cpu),
      .ce_ppu        (ce_ppu),
      .lock_drop_cnt (lock_drop_cnt)
   );

   // q = number of consecutive edges whose lock sample, seen two edges late, was high
   logic h0 = 0, h1 = 0;
   int   q = 0, m_drop = 0;
   logic e_ready, e_cpu, e_ppu;

   always @(posedge clk or posedge reset)
      if (reset) begin
         h0 <= 0; h1 <= 0; q <= 0; m_drop <= 0;
      end else begin
         h0 <= lock;
         h1 <= h0;
         q  <= h1 ? q + 1 : 0;
         if (q >= N && !h1 && m_drop < 255) m_drop <= m_drop + 1;
      end

   always_comb begin
      e_ready = (q >= N);
      e_ppu   = e_ready && ((q - N) % PD == PD - 1);
      e_cpu   = e_ready && ((q - N) % CD == CD - 1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (chk_on) begin
         chk("m_sys_reset", sys_reset, !e_ready);
         chk("m_ready", ready, e_ready);
         chk("m_ce_cpu", ce_cpu, e_cpu);
         chk("m_ce_ppu", ce_ppu, e_ppu);
         chk("m_drop", lock_drop_cnt, m_drop);
      end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic qualify(input string nm);
      wait_n(14);
      chk({nm, "_pre"}, sys_reset, 1);
      wait_n(1);
      chk({nm, "_run"}, sys_reset, 0);
      chk({nm, "_rdy"}, ready, 1);
   endtask

   initial begin
      wait_n(3);
      chk_on = 1;
      chk("rst_sys", sys_reset, 1);
      chk("rst_drop", lock_drop_cnt, 0);
      reset = 0;
      wait_n(50);
      chk("idle_sys", sys_reset, 1);
      chk("idle_rdy", ready, 0);
      chk("idle_ce", {ce_cpu, ce_ppu}, 0);
      lock = 1;
      wait_n(8);
      lock = 0;
      wait_n(2);
      lock = 1;
      qualify("glitch");
      chk("glitch_drop", lock_drop_cnt, 0);
      wait_n(2);
      chk("ppu_e16", ce_ppu, 0);
      wait_n(1);
      chk("ppu_e17", ce_ppu, 1);
      chk("cpu_e17", ce_cpu, 0);
      wait_n(8);
      chk("cpu_e25", {ce_cpu, ce_ppu}, 2'b11);
      lock = 0;
      wait_n(2);
      chk("fall_f1", sys_reset, 0);
      wait_n(1);
      chk("fall_f2", sys_reset, 1);
      chk("fall_ce", {ce_cpu, ce_ppu}, 0);
      chk("fall_drop", lock_drop_cnt, 1);
      lock = 1;
      qualify("relock");
      for (int i = 0; i < 300; i++) begin
         lock = 0;
         wait_n(4);
         lock = 1;
         wait_n(16);
      end
      chk("sat_drop", lock_drop_cnt, 255);
      chk("sat_rdy", ready, 1);
      @(negedge clk);
      #2 reset = 1;
      #1;
      chk("arst_sys", sys_reset, 1);
      chk("arst_rdy", ready, 0);
      chk("arst_drop", lock_drop_cnt, 0);
      @(negedge clk);
      reset = 0;
      qualify("post_rst");
      wait_n(20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
